tx_iq_sample_feeder: RTL and testbench
======================================

Name: tx_iq_sample_feeder

Overview:
Consumes 36-bit packed I/Q words from the TX I/Q FIFO read side (showahead, rdreq = pop) and presents one 16-bit I/Q pair per sample strobe to the TX upconversion chain.
Handles start-up priming, underflow (starvation) and frame-sync checking, and drains stale data while TX is disabled.
Sits directly downstream of the TX I/Q FIFO, in the FIFO read clock domain.

Parameters:
FLUSH_ON_IDLE, 1, when 1 drain FIFO (pop every cycle with valid) while in IDLE
CNT_WIDTH, 16, width of the saturating underflow counter

Ports:
clk  input  1  FIFO read / DSP clock
rst  input  1  synchronous, active-high reset
fifo_tdata  input  36  showahead FIFO word; lanes [35:27]=byte0, [26:18]=byte1, [17:9]=byte2, [8:0]=byte3; bit 8 of each lane = flag
fifo_tvalid  input  1  FIFO not empty
fifo_tready  output  1  pop (rdreq); combinational
sample_stb  input  1  one-cycle pulse at TX sample rate; never on consecutive cycles
tx_enable  input  1  PTT / transmit enable, synchronous to clk
tx_i  output  16  I sample, two's complement = {byte0[7:0], byte1[7:0]}
tx_q  output  16  Q sample = {byte2[7:0], byte3[7:0]}
tx_key  output  1  byte2 flag bit of the last accepted word
tx_valid  output  1  one-cycle pulse, new tx_i/tx_q presented
underflow_cnt  output  CNT_WIDTH  saturating count of starved strobes
sync_err_cnt  output  8  saturating count of words with byte0 flag = 0
state_o  output  2  current state encoding

Behaviour:
- Reset: state IDLE; tx_i = tx_q = 0; tx_key = 0; tx_valid = 0; both counters = 0. Reset dominates all inputs.
- States (state_o): IDLE = 0, PRIME = 1, RUN = 2, STARVED = 3.
- IDLE:
  - Outputs held at 0; tx_valid stays 0.
  - fifo_tready = fifo_tvalid if FLUSH_ON_IDLE = 1, else 0.
  - tx_enable = 1 -> PRIME on the next cycle. No pop occurs in the transition cycle.
- PRIME:
  - fifo_tready = 0; outputs 0.
  - A sample_stb in PRIME still produces tx_valid with zeros. It does not count as an underflow.
  - fifo_tvalid = 1 -> RUN.
- RUN:
  - fifo_tready = sample_stb & fifo_tvalid.
  - On a pop, at the next edge: tx_i/tx_q/tx_key load from fifo_tdata and tx_valid = 1. Latency from sample_stb to tx_valid is 1 clk.
  - sample_stb with fifo_tvalid = 0: no pop; tx_i/tx_q <= 0; tx_valid = 1; underflow_cnt++ (saturating); -> STARVED.
- STARVED:
  - Each sample_stb gives a zero sample with tx_valid and underflow_cnt++.
  - fifo_tvalid = 1 -> RUN. The next strobe pops normally.
  - If fifo_tvalid and sample_stb are high in the same cycle in STARVED: count the underflow, emit zero, no pop, then go to RUN.
- Sync check, on every pop: byte0 flag (fifo_tdata[35]) = 0 -> sync_err_cnt++ (saturating at 255). The word is still consumed but its I/Q is replaced with zeros. tx_key still loads.
- tx_enable = 0 in any non-IDLE state:
  - Next state is IDLE; outputs go to 0 at that edge.
  - A pop in the same cycle is suppressed: fifo_tready is gated by tx_enable.
- Counters clear only on rst. Both saturate: all-ones holds, no wrap.
- At most one pop per sample_stb in RUN. No pop is ever issued with fifo_tvalid = 0 (no underflow into the FIFO).

Optional Feature:
TX_IQ_RAMP_EN:
- Defined: on entering STARVED or IDLE from RUN, tx_i/tx_q do not jump to 0. Each subsequent sample_stb arithmetically shifts them right by 1 (sign-preserving), with tx_valid. -1 collapses to 0.
- Not defined: immediate zero as above.
- The ramp is restarted (overwritten) by a pop in RUN.

Test Plan:
- Reset, tx_enable = 0, FIFO empty -> state_o = 0, all outputs 0, no tx_valid on sample_stb.
- tx_enable = 1, FIFO holds word 0x1_12_0_34_0_56_0_78 (byte0 flag set), sample_stb -> exactly one fifo_tready pulse; next cycle tx_i = 0x1234, tx_q = 0x5678, tx_valid = 1, state RUN.
- Ten strobes with five words queued -> five pops, then underflow_cnt = 5, zeros output, state STARVED. Refill and strobe -> RUN, data resumes, one pop per strobe.
- Pop a word with bit 35 = 0 -> sync_err_cnt = 1, tx_i = tx_q = 0. 300 such words -> sync_err_cnt = 255.
- tx_enable falls in the same cycle as sample_stb with a valid word -> no pop, state IDLE next cycle. With FLUSH_ON_IDLE = 1 the FIFO drains to empty.
- TX_IQ_RAMP_EN defined, tx_i = 0x4000, starvation -> successive strobes give 0x2000, 0x1000, … 0. tx_i = 0xC000 -> 0xE000, … 0xFFFF, then 0.

Source files
------------

// File: rtl/tx_iq_sample_feeder.sv
// Pops packed I/Q words from a showahead FIFO and presents one 16-bit I/Q pair per sample strobe.
// Define TX_IQ_RAMP_EN to make outputs decay by halving, instead of snapping to zero, when data stops.
module tx_iq_sample_feeder #(
   parameter bit FLUSH_ON_IDLE = 1'b1,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [35:0]          fifo_tdata,
   input  logic                 fifo_tvalid,
   output logic                 fifo_tready,
   input  logic                 sample_stb,
   input  logic                 tx_enable,
   output logic [15:0]          tx_i,
   output logic [15:0]          tx_q,
   output logic                 tx_key,
   output logic                 tx_valid,
   output logic [CNT_WIDTH-1:0] underflow_cnt,
   output logic [7:0]           sync_err_cnt,
   output logic [1:0]           state_o
);

   typedef enum logic [1:0] {IDLE = 2'd0, PRIME = 2'd1, RUN = 2'd2, STARVED = 2'd3} state_t;

`ifdef TX_IQ_RAMP_EN
   localparam bit RAMP_EN = 1'b1;
`else
   localparam bit RAMP_EN = 1'b0;
`endif

   localparam logic [CNT_WIDTH-1:0] UND_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   state_t               state_q, state_d;
   logic [15:0]          i_q, i_d, q_q, q_d;
   logic                 key_q, key_d, vld_q, vld_d, ramp_q, ramp_d;
   logic [CNT_WIDTH-1:0] und_q, und_d;
   logic [7:0]           sync_q, sync_d;
   logic                 pop;
   logic                 unused_flags;

   // Arithmetic halving; -1 would stick forever, so it collapses to 0.
   function automatic logic [15:0] shr(input logic [15:0] x);
      return (x == 16'hFFFF) ? 16'h0000 : {x[15], x[15:1]};
   endfunction

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (tx_enable) state_d = PRIME;
         PRIME:   if (!tx_enable) state_d = IDLE; else if (fifo_tvalid) state_d = RUN;
         RUN:     if (!tx_enable) state_d = IDLE; else if (sample_stb && !fifo_tvalid) state_d = STARVED;
         STARVED: if (!tx_enable) state_d = IDLE; else if (fifo_tvalid) state_d = RUN;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      fifo_tready = 1'b0;
      pop         = 1'b0;
      i_d         = i_q;
      q_d         = q_q;
      key_d       = key_q;
      vld_d       = 1'b0;
      ramp_d      = ramp_q;
      und_d       = und_q;
      sync_d      = sync_q;
      case (state_q)
         IDLE: begin
            fifo_tready = FLUSH_ON_IDLE && fifo_tvalid && !tx_enable;
            if (RAMP_EN && ramp_q && !tx_enable) begin
               if (sample_stb) begin
                  i_d    = shr(i_q);
                  q_d    = shr(q_q);
                  vld_d  = 1'b1;
                  ramp_d = (shr(i_q) != 16'h0) || (shr(q_q) != 16'h0);
               end
            end else begin
               i_d    = 16'h0;
               q_d    = 16'h0;
               key_d  = 1'b0;
               ramp_d = 1'b0;
            end
         end
         PRIME: begin
            i_d   = 16'h0;
            q_d   = 16'h0;
            key_d = 1'b0;
            vld_d = sample_stb && tx_enable;
         end
         RUN: begin
            pop         = tx_enable && sample_stb && fifo_tvalid;
            fifo_tready = pop;
            if (!tx_enable) begin
               key_d  = 1'b0;
               ramp_d = RAMP_EN;
               i_d    = RAMP_EN ? i_q : 16'h0;
               q_d    = RAMP_EN ? q_q : 16'h0;
            end else if (pop) begin
               vld_d  = 1'b1;
               key_d  = fifo_tdata[17];
               ramp_d = 1'b0;
               if (fifo_tdata[35]) begin
                  i_d = {fifo_tdata[34:27], fifo_tdata[25:18]};
                  q_d = {fifo_tdata[16:9], fifo_tdata[7:0]};
               end else begin
                  // Word is out of frame alignment: consume it but never transmit it.
                  i_d    = 16'h0;
                  q_d    = 16'h0;
                  sync_d = (&sync_q) ? sync_q : sync_q + 8'd1;
               end
            end else if (sample_stb) begin
               vld_d = 1'b1;
               und_d = (&und_q) ? und_q : und_q + UND_ONE;
               i_d   = RAMP_EN ? shr(i_q) : 16'h0;
               q_d   = RAMP_EN ? shr(q_q) : 16'h0;
            end
         end
         STARVED: begin
            if (!tx_enable) begin
               i_d    = 16'h0;
               q_d    = 16'h0;
               key_d  = 1'b0;
               ramp_d = 1'b0;
            end else if (sample_stb) begin
               vld_d = 1'b1;
               und_d = (&und_q) ? und_q : und_q + UND_ONE;
               i_d   = RAMP_EN ? shr(i_q) : 16'h0;
               q_d   = RAMP_EN ? shr(q_q) : 16'h0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         i_q    <= 16'h0;
         q_q    <= 16'h0;
         key_q  <= 1'b0;
         vld_q  <= 1'b0;
         ramp_q <= 1'b0;
         und_q  <= '0;
         sync_q <= 8'h0;
      end else begin
         i_q    <= i_d;
         q_q    <= q_d;
         key_q  <= key_d;
         vld_q  <= vld_d;
         ramp_q <= ramp_d;
         und_q  <= und_d;
         sync_q <= sync_d;
      end
   end

   assign unused_flags  = ^{fifo_tdata[26], fifo_tdata[8], pop};
   assign tx_i          = i_q;
   assign tx_q          = q_q;
   assign tx_key        = key_q;
   assign tx_valid      = vld_q;
   assign underflow_cnt = und_q;
   assign sync_err_cnt  = sync_q;
   assign state_o       = state_q;

endmodule

// File: tb/tb_tx_iq_sample_feeder.sv
// Directed bench for tx_iq_sample_feeder: vector table for the main flow, hand sequences for
// starvation, sync-error saturation, idle flush and (when TX_IQ_RAMP_EN is defined) the output ramp.
module tb_tx_iq_sample_feeder;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst, fifo_tvalid, fifo_tready, sample_stb, tx_enable, tx_key, tx_valid;
   logic [35:0]   fifo_tdata;
   logic [15:0]   tx_i, tx_q;
   logic [CW-1:0] underflow_cnt;
   logic [7:0]    sync_err_cnt;
   logic [1:0]    state_o;

   always #5 clk = ~clk;

   tx_iq_sample_feeder #(.FLUSH_ON_IDLE(1'b1), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst), .fifo_tdata(fifo_tdata), .fifo_tvalid(fifo_tvalid),
      .fifo_tready(fifo_tready), .sample_stb(sample_stb), .tx_enable(tx_enable),
      .tx_i(tx_i), .tx_q(tx_q), .tx_key(tx_key), .tx_valid(tx_valid),
      .underflow_cnt(underflow_cnt), .sync_err_cnt(sync_err_cnt), .state_o(state_o)
   );

   typedef struct {
      logic          push;
      logic [35:0]   word;
      logic          stb;
      logic          en;
      logic          rdy;
      logic [1:0]    st;
      logic          vld;
      logic [15:0]   i;
      logic [15:0]   q;
      logic          key;
      logic [CW-1:0] und;
      logic [7:0]    sync;
   } vec_t;

   logic [35:0] fq[$];
   int          tests = 0, fails = 0, pops = 0, bad_pop = 0, vcnt = 0;
   logic        rdy_seen;

   function automatic logic [35:0] mkw(input logic f0, input logic [15:0] i, input logic f2,
                                       input logic [15:0] q);
      return {f0, i[15:8], 1'b0, i[7:0], f2, q[15:8], 1'b0, q[7:0]};
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   // One clock: drive at negedge, capture the combinational pop, clock, return at next negedge.
   task automatic tick(input logic stb, input logic en);
      sample_stb  = stb;
      tx_enable   = en;
      fifo_tvalid = (fq.size() != 0);
      fifo_tdata  = fifo_tvalid ? fq[0] : 36'h0;
      #1;
      rdy_seen = fifo_tready;
      if (fifo_tready === 1'b1 && !fifo_tvalid) bad_pop++;
      @(posedge clk);
      if (rdy_seen === 1'b1 && fq.size() != 0) begin
         void'(fq.pop_front());
         pops++;
      end
      @(negedge clk);
      if (tx_valid === 1'b1) vcnt++;
      sample_stb = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      rst = 1'b0;
      fq.delete();
   endtask

`ifdef TX_IQ_RAMP_EN
   localparam logic [15:0] R5I = 16'h091A, R5Q = 16'h2B3C;
`else
   localparam logic [15:0] R5I = 16'h0000, R5Q = 16'h0000;
`endif

   initial begin
      vec_t        tbl[16];
      logic [35:0] w1, w2, w3, w4;

      w1 = mkw(1'b1, 16'h1234, 1'b0, 16'h5678);
      w2 = mkw(1'b1, 16'hABCD, 1'b1, 16'h0102);
      w3 = mkw(1'b0, 16'h7777, 1'b0, 16'h8888);
      w4 = mkw(1'b1, 16'h1111, 1'b0, 16'h2222);
      //          push  word   stb   en    rdy   st    vld   i         q         key   und   sync
      tbl[0]  = '{1'b0, 36'h0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0,    16'h0,    1'b0, 4'd0, 8'd0};
      tbl[1]  = '{1'b1, w1,    1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 16'h0,    16'h0,    1'b0, 4'd0, 8'd0};
      tbl[2]  = '{1'b0, 36'h0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 16'h0,    16'h0,    1'b0, 4'd0, 8'd0};
      tbl[3]  = '{1'b0, 36'h0, 1'b1, 1'b1, 1'b1, 2'd2, 1'b1, 16'h1234, 16'h5678, 1'b0, 4'd0, 8'd0};
      tbl[4]  = '{1'b0, 36'h0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 16'h1234, 16'h5678, 1'b0, 4'd0, 8'd0};
      tbl[5]  = '{1'b0, 36'h0, 1'b1, 1'b1, 1'b0, 2'd3, 1'b1, R5I,      R5Q,      1'b0, 4'd1, 8'd0};
      tbl[6]  = '{1'b1, w2,    1'b0, 1'b1, 1'b0, 2'd2, 1'b0, R5I,      R5Q,      1'b0, 4'd1, 8'd0};
      tbl[7]  = '{1'b0, 36'h0, 1'b1, 1'b1, 1'b1, 2'd2, 1'b1, 16'hABCD, 16'h0102, 1'b1, 4'd1, 8'd0};
      tbl[8]  = '{1'b1, w3,    1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 16'hABCD, 16'h0102, 1'b1, 4'd1, 8'd0};
      tbl[9]  = '{1'b0, 36'h0, 1'b1, 1'b1, 1'b1, 2'd2, 1'b1, 16'h0,    16'h0,    1'b0, 4'd1, 8'd1};
      tbl[10] = '{1'b1, w4,    1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 16'h0,    16'h0,    1'b0, 4'd1, 8'd1};
      tbl[11] = '{1'b0, 36'h0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0,    16'h0,    1'b0, 4'd1, 8'd1};
      tbl[12] = '{1'b0, 36'h0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 16'h0,    16'h0,    1'b0, 4'd1, 8'd1};
      tbl[13] = '{1'b0, 36'h0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 16'h0,    16'h0,    1'b0, 4'd1, 8'd1};
      tbl[14] = '{1'b0, 36'h0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 16'h0,    16'h0,    1'b0, 4'd1, 8'd1};
      tbl[15] = '{1'b0, 36'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0,    16'h0,    1'b0, 4'd1, 8'd1};

      rst = 1'b1; sample_stb = 1'b0; tx_enable = 1'b0; fifo_tvalid = 1'b0; fifo_tdata = 36'h0;
      @(negedge clk);

      // Reset dominates an enabled strobe with data waiting.
      fq.push_back(w1);
      tick(1'b1, 1'b1);
      tick(1'b1, 1'b1);
      chk("reset_state", 32'(state_o), 32'd0);
      chk("reset_rdy", 32'(rdy_seen), 32'd0);
      chk("reset_vld", 32'(tx_valid), 32'd0);
      chk("reset_iq", {tx_i, tx_q}, 32'h0);
      chk("reset_key", 32'(tx_key), 32'd0);
      chk("reset_cnts", {20'h0, underflow_cnt, sync_err_cnt}, 32'h0);
      rst = 1'b0;
      fq.delete();

      for (int r = 0; r < 16; r++) begin
         if (tbl[r].push) fq.push_back(tbl[r].word);
         tick(tbl[r].stb, tbl[r].en);
         chk($sformatf("row%0d_rdy", r), 32'(rdy_seen), 32'(tbl[r].rdy));
         chk($sformatf("row%0d_state", r), 32'(state_o), 32'(tbl[r].st));
         chk($sformatf("row%0d_vld", r), 32'(tx_valid), 32'(tbl[r].vld));
         chk($sformatf("row%0d_iq", r), {tx_i, tx_q}, {tbl[r].i, tbl[r].q});
         chk($sformatf("row%0d_key", r), 32'(tx_key), 32'(tbl[r].key));
         chk($sformatf("row%0d_und", r), 32'(underflow_cnt), 32'(tbl[r].und));
         chk($sformatf("row%0d_sync", r), 32'(sync_err_cnt), 32'(tbl[r].sync));
      end

      // Ten strobes against five queued words, then recover.
      do_reset();
      for (int k = 0; k < 5; k++) fq.push_back(mkw(1'b1, 16'h0100 + 16'(k), 1'b0, 16'h0200 + 16'(k)));
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b1);
      chk("starve_enter_run", 32'(state_o), 32'd2);
      pops = 0; vcnt = 0;
      for (int k = 0; k < 10; k++) begin
         tick(1'b1, 1'b1);
         if (k < 5) chk($sformatf("starve_data%0d", k), {tx_i, tx_q},
                        {16'h0100 + 16'(k), 16'h0200 + 16'(k)});
         tick(1'b0, 1'b1);
      end
      chk("starve_pops", pops, 5);
      chk("starve_vld_cnt", vcnt, 10);
      chk("starve_und", 32'(underflow_cnt), 32'd5);
      chk("starve_state", 32'(state_o), 32'd3);
`ifndef TX_IQ_RAMP_EN
      chk("starve_zero", {tx_i, tx_q}, 32'h0);
`endif
      for (int k = 0; k < 3; k++) fq.push_back(mkw(1'b1, 16'h0300 + 16'(k), 1'b0, 16'h0400 + 16'(k)));
      tick(1'b1, 1'b1);
      chk("refill_same_cycle_nopop", 32'(rdy_seen), 32'd0);
      chk("refill_same_cycle_und", 32'(underflow_cnt), 32'd6);
      chk("refill_same_cycle_vld", 32'(tx_valid), 32'd1);
      chk("refill_state", 32'(state_o), 32'd2);
      pops = 0;
      for (int k = 0; k < 3; k++) begin
         tick(1'b0, 1'b1);
         tick(1'b1, 1'b1);
         chk($sformatf("resume_data%0d", k), {tx_i, tx_q}, {16'h0300 + 16'(k), 16'h0400 + 16'(k)});
         chk($sformatf("resume_vld%0d", k), 32'(tx_valid), 32'd1);
      end
      chk("resume_pops", pops, 3);
      tick(1'b0, 1'b1);
      tick(1'b1, 1'b1);
      chk("restarve_und", 32'(underflow_cnt), 32'd7);

      // Sync-error saturation, then underflow saturation.
      do_reset();
      fq.push_back(mkw(1'b0, 16'hAAAA, 1'b1, 16'h5555));
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b1);
      for (int k = 0; k < 300; k++) begin
         if (fq.size() == 0) fq.push_back(mkw(1'b0, 16'hAAAA, 1'b1, 16'h5555));
         tick(1'b1, 1'b1);
         if (k == 0) begin
            chk("sync_first_cnt", 32'(sync_err_cnt), 32'd1);
            chk("sync_first_iq", {tx_i, tx_q}, 32'h0);
            chk("sync_first_key", 32'(tx_key), 32'd1);
            chk("sync_first_vld", 32'(tx_valid), 32'd1);
         end
         tick(1'b0, 1'b1);
      end
      chk("sync_sat", 32'(sync_err_cnt), 32'd255);
      for (int k = 0; k < 20; k++) begin
         tick(1'b1, 1'b1);
         tick(1'b0, 1'b1);
      end
      chk("und_sat", 32'(underflow_cnt), 32'd15);
      chk("sync_held", 32'(sync_err_cnt), 32'd255);

      // Idle flush drains the FIFO without emitting samples.
      do_reset();
      for (int k = 0; k < 4; k++) fq.push_back(w4);
      pops = 0; vcnt = 0;
      for (int k = 0; k < 6; k++) tick(1'(k % 2), 1'b0);
      chk("flush_pops", pops, 4);
      chk("flush_empty", fq.size(), 0);
      chk("flush_no_vld", vcnt, 0);

`ifdef TX_IQ_RAMP_EN
      do_reset();
      fq.push_back(mkw(1'b1, 16'h4000, 1'b0, 16'hC000));
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b1);
      tick(1'b1, 1'b1);
      chk("ramp_load", {tx_i, tx_q}, 32'h4000C000);
      tick(1'b0, 1'b1);
      tick(1'b1, 1'b1);
      chk("ramp_step1", {tx_i, tx_q}, 32'h2000E000);
      for (int k = 0; k < 13; k++) begin
         tick(1'b0, 1'b1);
         tick(1'b1, 1'b1);
      end
      chk("ramp_step14", {tx_i, tx_q}, 32'h0001FFFF);
      tick(1'b0, 1'b1);
      tick(1'b1, 1'b1);
      chk("ramp_step15", {tx_i, tx_q}, 32'h0);
      fq.push_back(mkw(1'b1, 16'h0008, 1'b0, 16'hFFF0));
      tick(1'b0, 1'b1);
      tick(1'b1, 1'b1);
      tick(1'b0, 1'b0);
      chk("ramp_idle_hold", {tx_i, tx_q}, 32'h0008FFF0);
      tick(1'b1, 1'b0);
      chk("ramp_idle_step", {tx_i, tx_q}, 32'h0004FFF8);
      chk("ramp_idle_vld", 32'(tx_valid), 32'd1);
`endif

      chk("no_pop_when_empty", bad_pop, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
